// File: rtl/line_evict_reader_pkg.sv
// Shared types and sizing for the cache line eviction reader.
// Holds the FSM state encoding and the word-slicing width derivation.
package line_evict_reader_pkg;

  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_INDEX_WIDTH = 9;
  localparam int DEF_WORD_BITS   = 3;
  localparam int DEF_WORD_CNT    = 2 ** DEF_WORD_BITS;
  localparam int DEF_SMALL_WIDTH = DEF_DATA_WIDTH / DEF_WORD_CNT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  function automatic int small_width(input int data_width, input int word_bits);
    return data_width / (2 ** word_bits);
  endfunction

endpackage

// File: rtl/line_evict_reader_if.sv
// Request, array port-b and word-stream signals of the eviction reader.
// master = the engine, slave = controller/array/writeback side.
interface line_evict_reader_if #(
  parameter int DATA_WIDTH  = line_evict_reader_pkg::DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH = line_evict_reader_pkg::DEF_INDEX_WIDTH,
  parameter int WORD_BITS   = line_evict_reader_pkg::DEF_WORD_BITS
);
  localparam int WORDS = 2 ** WORD_BITS;
  localparam int SW    = DATA_WIDTH / WORDS;

  logic                   req_valid;
  logic                   req_ready;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [WORDS-1:0]       req_mask;
  logic [INDEX_WIDTH-1:0] arr_addr_b;
  logic                   arr_we_b;
  logic [DATA_WIDTH-1:0]  arr_q_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [SW-1:0]          out_data;
  logic [WORD_BITS-1:0]   out_word;
  logic [INDEX_WIDTH-1:0] out_index;
  logic                   out_last;
  logic                   done;

  modport master (
    input  req_valid, req_index, req_mask, arr_q_b, out_ready,
    output req_ready, arr_addr_b, arr_we_b, out_valid, out_data,
           out_word, out_index, out_last, done
  );

  modport slave (
    output req_valid, req_index, req_mask, arr_q_b, out_ready,
    input  req_ready, arr_addr_b, arr_we_b, out_valid, out_data,
           out_word, out_index, out_last, done
  );

endinterface

// File: rtl/line_evict_reader_mask_next_bit.sv
// Combinational priority finder over the dirty mask: lowest set bit, and next set
// bit strictly above a pointer (o_none when there is none, i.e. pointer is last).
module mask_next_bit #(
  parameter int WORD_BITS = 3
) (
  input  logic [(2**WORD_BITS)-1:0] i_mask,
  input  logic [WORD_BITS-1:0]      i_ptr,
  output logic [WORD_BITS-1:0]      o_next,
  output logic                      o_none,
  output logic [WORD_BITS-1:0]      o_lowest
);
  localparam int WORDS = 2 ** WORD_BITS;

  // Descending scans: the last hit written is the lowest qualifying bit.
  always_comb begin
    o_next   = '0;
    o_none   = 1'b1;
    o_lowest = '0;
    for (int j = WORDS - 1; j >= 0; j--) begin
      if (i_mask[j] && (j > int'(i_ptr))) begin
        o_next = WORD_BITS'(j);
        o_none = 1'b0;
      end
    end
    for (int j = WORDS - 1; j >= 0; j--) begin
      if (i_mask[j]) begin
        o_lowest = WORD_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/line_evict_reader.sv
// Reads one cache line via array port b and streams its dirty words out;
// first beat 3 cycles after accept, beats hold stable while out_ready is low.
module line_evict_reader
  import line_evict_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int WORD_BITS   = DEF_WORD_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  line_evict_reader_if.master  bus
);
  localparam int WORDS = 2 ** WORD_BITS;
  localparam int SW    = small_width(DATA_WIDTH, WORD_BITS);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [WORDS-1:0]       r_mask;
  logic [DATA_WIDTH-1:0]  r_line;
  logic [WORD_BITS-1:0]   r_ptr;
  logic                   r_done;

  logic [WORD_BITS-1:0]   w_next;
  logic [WORD_BITS-1:0]   w_lowest;
  logic                   w_none;
  logic                   w_req_ready;
  logic                   w_out_valid;
  logic                   w_out_last;
  logic                   w_accept;
  logic                   w_beat;

  mask_next_bit #(.WORD_BITS(WORD_BITS)) u_next (
    .i_mask   (r_mask),
    .i_ptr    (r_ptr),
    .o_next   (w_next),
    .o_none   (w_none),
    .o_lowest (w_lowest)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        // An empty mask completes in place: no array read, only the done pulse.
        if (bus.req_valid && (bus.req_mask != '0)) begin
          w_state_nxt = READ;
        end
      end
      READ:  w_state_nxt = LATCH;
      LATCH: w_state_nxt = SEND;
      SEND: begin
        w_out_valid = 1'b1;
        w_out_last  = w_none;
        if (bus.out_ready && w_none) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = w_req_ready && bus.req_valid;
  assign w_beat   = w_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= '0;
      r_mask  <= '0;
      r_line  <= '0;
      r_ptr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (w_accept && (bus.req_mask == '0)) || (w_beat && w_none);
      if (w_accept) begin
        r_index <= bus.req_index;
        r_mask  <= bus.req_mask;
      end
      if (r_state == LATCH) begin
        r_line <= bus.arr_q_b;
        r_ptr  <= w_lowest;
      end else if (w_beat && !w_none) begin
        r_ptr <= w_next;
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.arr_addr_b = r_index;
  assign bus.arr_we_b   = 1'b0;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_last   = w_out_last;
  assign bus.out_data   = r_line[r_ptr*SW +: SW];
  assign bus.out_word   = r_ptr;
  assign bus.out_index  = r_index;
  assign bus.done       = r_done;

endmodule

// File: doc/line_evict_reader.md
Name: line_evict_reader

Overview:
- Read-side engine for the SIMD cache data array.
- Accepts an eviction request (set index plus a dirty-word mask) and reads the full line through the array's port b.
- Latches the line, then serialises only the dirty words onto a valid/ready word stream toward the memory-side writeback path.
- Sits between the cache controller and the writeback buffer; it never writes the array.

Parameters:
- DATA_WIDTH, 256, line width in bits
- INDEX_WIDTH, 9, set index width
- WORD_BITS, 3, log2 of words per line (derived SMALL_DATA_WIDTH = DATA_WIDTH/2**WORD_BITS)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  eviction request valid
- req_ready  out  1  engine can accept a request
- req_index  in  INDEX_WIDTH  set index to read
- req_mask  in  2**WORD_BITS  dirty-word mask; bit j = send word j
- arr_addr_b  out  INDEX_WIDTH  array port-b address
- arr_we_b  out  1  array port-b write enable, tied 0
- arr_q_b  in  DATA_WIDTH  array port-b read data, 1-cycle registered latency
- out_valid  out  1  word beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  SMALL_DATA_WIDTH  word j = line bits [SW*(j+1)-1 : SW*j]
- out_word  out  WORD_BITS  index j of the current word
- out_index  out  INDEX_WIDTH  set index of the line being sent
- out_last  out  1  current beat is the highest set mask bit
- done  out  1  one-cycle pulse when the request completes

Behaviour:
- Reset (async assert, any state): state=IDLE; req_ready=1, out_valid=0, out_last=0, done=0, arr_addr_b=0, index/mask/line registers=0. arr_we_b is 0 at all times.
- FSM states: IDLE, READ, LATCH, SEND.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: register index and mask.
  - Mask nonzero: go to READ.
  - Mask zero: stay IDLE, assert done next cycle; no array access, no beats.
- READ: arr_addr_b = registered index; req_ready=0. Array samples the address at the end of this cycle. Go to LATCH.
- LATCH:
  - arr_q_b is valid; capture the full line into the line buffer at the end of the cycle.
  - Load word pointer = lowest set mask bit.
  - Go to SEND.
- Latency: accept at edge E0 -> READ -> LATCH -> first out_valid in the cycle after E2.
- SEND:
  - out_valid=1; out_data/out_word reflect the word pointer; out_index = registered index.
  - out_last=1 iff no mask bit above the pointer is set.
  - On out_valid&out_ready:
    - not last: pointer advances to the next higher set mask bit (skips clean words; no wrap-around);
    - last: go to IDLE, with done=1 in the following cycle.
  - While out_valid&!out_ready: all out_* held stable, no drop or duplicate.
- done is a single-cycle pulse; req_ready returns to 1 in the same cycle as done. A new request may be accepted in that cycle.
- The array contents are read once per request. The caller guarantees no port-a write to the same index between accept and the end of LATCH; the engine does not check this.
- Reset mid-operation: beat in flight is abandoned, done is not pulsed, and the request is lost.

Decomposition:
- Shared cache package holds:
  - state enum (IDLE/READ/LATCH/SEND);
  - SMALL_DATA_WIDTH derivation;
  - word-count constant 2**WORD_BITS.
- One natural sub-module: mask_next_bit, a combinational priority finder.
  - Inputs: mask and current pointer.
  - Outputs: the next set bit strictly above the pointer, a "none" flag (drives out_last), and the lowest set bit for the LATCH load.

Test Plan:
- Full mask: index 5 holds word k = 32'h1111_1111*k; mask 8'hFF, out_ready=1.
  - First out_valid 3 cycles after accept; 8 back-to-back beats with out_word 0..7 and matching data; out_last only on word 7; done one cycle after the last beat.
- Sparse mask 8'h81 on index 9 -> exactly two beats, word 0 (last=0) then word 7 (last=1); done pulses once.
- Single-word mask 8'h04 -> one beat, word 2, out_last=1; arr_addr_b = index during READ.
- Empty mask 8'h00 -> no out_valid ever; done pulses in the cycle after accept; req_ready stays 1.
- Backpressure: mask 8'hFF with out_ready pattern 1,0,0,1,0,1... -> out_data/out_word/out_last stable while stalled; 8 unique beats in order; done after word 7.
- Reset mid-SEND: drop rst_n after the 3rd beat of an 8'hFF request.
  - out_valid goes 0 immediately and done never pulses.
  - After release: req_ready=1, and a new request (mask 8'h01) completes normally.
